// File: rtl/register_file_sb.sv
// Two-read, one-write register file with per-register busy (scoreboard) bits.
// Reads stall while a source is reserved, unless this cycle's write-back supplies it.
module register_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              stall
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                rs_hit, rt_hit;
    logic                rs_blocked, rt_blocked;
    logic                rd_fire;
    logic [DATA_W-1:0]   rs_next, rt_next;

    // Read handshake: rd_en is a request held by the requester; it is accepted on
    // an edge where stall=0, and the captured data is flagged by rd_valid=1 for
    // exactly the next cycle. stall acts as the inverse of ready.
    always_comb begin
        rs_hit     = wr_en && (wr_addr == rs_addr);
        rt_hit     = wr_en && (wr_addr == rt_addr);
        rs_blocked = busy[rs_addr] && !rs_hit;
        rt_blocked = busy[rt_addr] && !rt_hit;
        stall      = rd_en && (rs_blocked || rt_blocked);
        rd_fire    = rd_en && !stall;
        rs_next    = rs_hit ? wr_data : regs[rs_addr];
        rt_next    = rt_hit ? wr_data : regs[rt_addr];
        if (ZERO_REG != 0 && rs_addr == '0) rs_next = '0;
        if (ZERO_REG != 0 && rt_addr == '0) rt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy     <= '0;
            rs_data  <= '0;
            rt_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (wr_en && wr_addr == ADDR_W'(i)) regs[i] <= wr_data;
                    // A new reservation outranks the clearing write-back.
                    if (rsv_en && rsv_addr == ADDR_W'(i))
                        busy[i] <= 1'b1;
                    else if (wr_en && wr_addr == ADDR_W'(i))
                        busy[i] <= 1'b0;
                end
            end
            if (rd_fire) begin
                rs_data <= rs_next;
                rt_data <= rt_next;
            end
            rd_valid <= rd_fire;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 share the same stimulus; each step lists hand-computed expectations.
module tb_register_file_sb;

    logic       clk = 1'b0;
    logic       rst, rd_en, wr_en, rsv_en;
    logic [1:0] rs_addr, rt_addr, wr_addr, rsv_addr;
    logic [7:0] wr_data;
    logic [7:0] rs_data, rt_data, rs_data_z, rt_data_z;
    logic       rd_valid, stall, rd_valid_z, stall_z;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    register_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .stall(stall)
    );

    register_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data_z), .rt_data(rt_data_z), .rd_valid(rd_valid_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .stall(stall_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
        rs_addr = '0; rt_addr = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] rs, input logic [1:0] rt);
        rd_en = 1'b1; rs_addr = rs; rt_addr = rt;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic rsv(input logic [1:0] a);
        rsv_en = 1'b1; rsv_addr = a;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        idle();
        #1;
        check("reset_rs_data", rs_data, 8'h00);
        check("reset_rt_data", rt_data, 8'h00);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_stall", stall, 1'b0);

        // Write r1, then read r1/r2.
        idle(); wr(2'd1, 8'h5A); tick();
        idle(); rd(2'd1, 2'd2); #1;
        check("s1_stall", stall, 1'b0);
        tick();
        check("s1_rs_data", rs_data, 8'h5A);
        check("s1_rt_data", rt_data, 8'h00);
        check("s1_rd_valid", rd_valid, 1'b1);
        idle(); tick();
        check("idle_rd_valid", rd_valid, 1'b0);
        check("idle_hold_rs", rs_data, 8'h5A);

        // Write-first bypass on both ports, then a back-to-back read.
        idle(); wr(2'd3, 8'h33); rd(2'd3, 2'd3); tick();
        check("s2_rs_bypass", rs_data, 8'h33);
        check("s2_rt_bypass", rt_data, 8'h33);
        check("s2_rd_valid", rd_valid, 1'b1);
        idle(); rd(2'd1, 2'd3); tick();
        check("b2b_rs_data", rs_data, 8'h5A);
        check("b2b_rt_data", rt_data, 8'h33);
        check("b2b_rd_valid", rd_valid, 1'b1);

        // Reserve r2; a read of r2 stalls until the write-back arrives.
        idle(); rsv(2'd2); tick();
        check("rsv_rd_valid", rd_valid, 1'b0);
        idle(); rd(2'd2, 2'd1); #1;
        check("s3_stall", stall, 1'b1);
        tick();
        check("s3_stalled_valid", rd_valid, 1'b0);
        check("s3_hold_rs", rs_data, 8'h5A);
        check("s3_hold_rt", rt_data, 8'h33);
        wr(2'd2, 8'h77); #1;
        check("s3_wb_stall", stall, 1'b0);
        tick();
        check("s3_wb_rs_data", rs_data, 8'h77);
        check("s3_wb_rt_data", rt_data, 8'h5A);
        check("s3_wb_valid", rd_valid, 1'b1);
        idle(); rd(2'd2, 2'd2); #1;
        check("s3_busy_cleared", stall, 1'b0);
        tick();
        check("s3_reread", rs_data, 8'h77);

        // A blocked rt source also stalls; no request means no stall.
        idle(); rsv(2'd0); tick();
        idle(); rd(2'd1, 2'd0); #1;
        check("rt_blocked_stall", stall, 1'b1);
        rd_en = 1'b0; #1;
        check("no_req_stall", stall, 1'b0);
        tick();
        idle(); wr(2'd0, 8'h9C); tick();
        idle(); rd(2'd0, 2'd1); #1;
        check("r0_released_stall", stall, 1'b0);
        tick();
        check("r0_rs_data", rs_data, 8'h9C);
        check("r0_rt_data", rt_data, 8'h5A);

        // Same-cycle reserve and write: write lands, reservation survives.
        idle(); rsv(2'd1); wr(2'd1, 8'h10); tick();
        idle(); rd(2'd1, 2'd3); #1;
        check("s4_stall", stall, 1'b1);
        check("s4_r1_value", dut.regs[1], 8'h10);
        tick();
        check("s4_rd_valid", rd_valid, 1'b0);

        // Load all registers, reserve r3, then reset with competing activity.
        for (int i = 0; i < 4; i++) begin
            idle(); wr(2'(i), 8'(i + 1)); tick();
        end
        idle(); rsv(2'd3); tick();
        idle(); rd(2'd3, 2'd0); #1;
        check("s5_pre_stall", stall, 1'b1);
        rst = 1'b1; wr(2'd2, 8'hAA); rsv(2'd1); #1;
        check("s5_rst_stall", stall, 1'b1);
        tick();
        idle(); rd(2'd3, 2'd1); #1;
        check("s5_post_valid", rd_valid, 1'b0);
        check("s5_post_rs", rs_data, 8'h00);
        check("s5_post_rt", rt_data, 8'h00);
        check("s5_post_stall", stall, 1'b0);
        tick();
        check("s5_read_rs", rs_data, 8'h00);
        check("s5_read_rt", rt_data, 8'h00);
        check("s5_read_valid", rd_valid, 1'b1);
        idle(); rd(2'd2, 2'd0); tick();
        check("s5_r2_cleared", rs_data, 8'h00);
        check("s5_r0_cleared", rt_data, 8'h00);

        // Zero register: writes and reservations to r0 are ignored.
        idle(); wr(2'd0, 8'hFF); tick();
        idle(); rsv(2'd0); tick();
        idle(); rd(2'd0, 2'd0); #1;
        check("z_stall", stall_z, 1'b0);
        check("nz_r0_stall", stall, 1'b1);
        tick();
        check("z_rs_data", rs_data_z, 8'h00);
        check("z_rd_valid", rd_valid_z, 1'b1);
        check("nz_rd_valid", rd_valid, 1'b0);
        wr(2'd0, 8'hEE); #1;
        check("nz_bypass_stall", stall, 1'b0);
        tick();
        check("z_bypass_rs", rs_data_z, 8'h00);
        check("z_bypass_rt", rt_data_z, 8'h00);
        check("nz_bypass_rs", rs_data, 8'hEE);
        idle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the width of each register and data port.
REQ-002 The block SHALL have parameter ADDR_W, default 2, the register address width, with NUM_REGS = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, as follows:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have the following other ports:
- rd_en  input  1  read request.
- rs_addr  input  ADDR_W  port-A read address.
- rt_addr  input  ADDR_W  port-B read address.
- rs_data  output  DATA_W  registered port-A read data.
- rt_data  output  DATA_W  registered port-B read data.
- rd_valid  output  1  read data valid.
- wr_en  input  1  write-back enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rsv_en  input  1  reserve a destination register (mark it busy).
- rsv_addr  input  ADDR_W  register to reserve.
- stall  output  1  combinational; the read request is blocked this cycle.

Function
REQ-006 Register contents SHALL change only on a rising clk edge with wr_en=1, which writes wr_data into register wr_addr.
REQ-007 Each register SHALL carry a busy bit:
- rsv_en=1 at an edge sets busy[rsv_addr].
- wr_en=1 at an edge clears busy[wr_addr].
REQ-008 If rsv_en and wr_en target the same address in the same cycle, the register SHALL be written and busy SHALL end set (the new reservation wins).
REQ-009 A source SHALL count as blocked when its busy bit is set and it is not satisfied this cycle by wr_en=1 with wr_addr equal to that source address.
REQ-010 stall SHALL be rd_en AND (rs blocked OR rt blocked), evaluated combinationally from the current state and inputs.
REQ-011 A read with rd_en=1 and stall=0 SHALL:
- capture both source values into rs_data/rt_data at the edge;
- drive rd_valid=1 for exactly the following cycle (1-cycle latency).
REQ-012 On a same-cycle write to a read address, the captured value SHALL be wr_data (write-first bypass), independently per port.
REQ-013 When rd_en=0 or stall=1, rs_data/rt_data SHALL hold their previous values and rd_valid SHALL be 0 in the next cycle.
REQ-014 When rs_addr equals rt_addr, both ports SHALL return the same value.
REQ-015 With ZERO_REG=1, register 0 SHALL behave as follows:
- it always reads 0, including via the bypass;
- writes to it are ignored;
- rsv_en to it is ignored, so it is never busy.
REQ-016 Back-to-back reads on consecutive cycles SHALL each produce rd_valid=1 one cycle after their request, with no bubble.
REQ-017 Writes SHALL be accepted regardless of the busy state; a write to a non-busy register leaves its busy bit 0.

Reset
REQ-018 rst=1 at an edge SHALL force the following, overriding any simultaneous wr_en, rsv_en or rd_en:
- all registers to 0;
- all busy bits to 0;
- rs_data and rt_data to 0;
- rd_valid to 0.
REQ-019 While rst=1, stall SHALL still follow REQ-010; because reset has cleared all busy bits, stall SHALL be 0 from the first cycle after the reset edge.
REQ-020 A reservation or read in flight when rst asserts SHALL be discarded, with no residual busy bit or rd_valid afterwards.

Verification
REQ-021 (DATA_W=8, ADDR_W=2, ZERO_REG=0) The bench SHALL cover the following directed scenarios:
- Write 8'h5A to r1, then read rs=1, rt=2 -> next cycle rs_data=5A, rt_data=00, rd_valid=1.
- In the same cycle write 8'h33 to r3 and read rs=3, rt=3 -> rs_data=rt_data=33 (bypass).
- rsv r2; next cycle read rs=2 -> stall=1, rd_valid=0 the cycle after; write 8'h77 to r2 with the read still held -> stall=0 that cycle, rs_data=77 next cycle, busy[2] cleared.
- Same cycle rsv r1 and write 8'h10 to r1; then read r1 -> stall=1 (busy still set); r1 holds 10.
- Load r0..r3 with 1..4, rsv r3, then assert rst together with wr_en -> afterwards all reads return 0, stall=0, rd_valid=0 in the cycle after reset.
- With ZERO_REG=1, write 8'hFF to r0 and rsv r0, then read rs=0 -> rs_data=00, stall=0.
